// File: rtl/alu_seq.sv
// Multi-byte ALU sequencer: reads A/B bytes from data memory, chains carry through
// the 8-bit ALU, writes results back. Optional parity accumulator: ALU_SEQ_PARITY_EN.
module alu_seq (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] op,
   input  logic [1:0] len_m1,
   input  logic       cin_use,
   input  logic [7:0] a_base,
   input  logic [7:0] b_base,
   input  logic [7:0] d_base,
   output logic [7:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic [3:0] alu_cmd,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic       alu_ci,
   input  logic [7:0] alu_rslt,
   input  logic       alu_co,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       cf,
   output logic       pf,
   output logic [2:0] dbg_state
);
   // Handshake: start is a request sampled only in IDLE; done is a one-cycle
   // completion pulse and err is meaningful only while done is high.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_RDA = 3'd1, S_RDB = 3'd2, S_LATB = 3'd3, S_WR = 3'd4, S_DONE = 3'd5
   } state_t;

   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_LSL = 4'd2, OP_ASR = 4'd3, OP_LSR = 4'd4;

   state_t     state_q, state_d;
   logic [3:0] op_q, op_d;
   logic [1:0] len_q, len_d;
   logic [1:0] i_q, i_d;
   logic [7:0] a_base_q, a_base_d, b_base_q, b_base_d, d_base_q, d_base_d;
   logic [7:0] a_q, a_d, b_q, b_d;
   logic       carry_q, carry_d;
   logic       cf_q, cf_d;
   logic       err_q, err_d;
   logic       desc, chain, last;

   assign desc  = (op_q == OP_ASR) || (op_q == OP_LSR);
   assign chain = (op_q <= OP_LSR);
   assign last  = desc ? (i_q == 2'd0) : (i_q == len_q);

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      len_d    = len_q;
      i_d      = i_q;
      a_base_d = a_base_q;
      b_base_d = b_base_q;
      d_base_d = d_base_q;
      a_d      = a_q;
      b_d      = b_q;
      carry_d  = carry_q;
      cf_d     = cf_q;
      err_d    = err_q;
      rd_addr  = 8'h00;
      wr_en    = 1'b0;
      wr_addr  = 8'h00;
      wr_data  = 8'h00;
      alu_cmd  = 4'd0;
      alu_a    = 8'h00;
      alu_b    = 8'h00;
      alu_ci   = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d     = op;
               len_d    = len_m1;
               a_base_d = a_base;
               b_base_d = b_base;
               d_base_d = d_base;
               err_d    = op[3];
               i_d      = ((op == OP_ASR) || (op == OP_LSR)) ? len_m1 : 2'd0;
               // SUB adds ~B, so its default carry-in of 1 completes the two's complement.
               case (op)
                  OP_ADD, OP_LSL, OP_LSR: carry_d = cin_use ? cf_q : 1'b0;
                  OP_SUB:                 carry_d = cin_use ? cf_q : 1'b1;
                  default:                carry_d = 1'b0;
               endcase
               state_d = op[3] ? S_DONE : S_RDA;
            end
         end
         S_RDA: begin
            rd_addr = a_base_q + {6'd0, i_q};
            state_d = S_RDB;
         end
         S_RDB: begin
            rd_addr = b_base_q + {6'd0, i_q};
            a_d     = rd_data;
            state_d = S_LATB;
         end
         S_LATB: begin
            b_d     = rd_data;
            state_d = S_WR;
         end
         S_WR: begin
            case (op_q)
               OP_ADD, OP_SUB: alu_cmd = 4'd0;
               OP_ASR:         alu_cmd = (i_q == len_q) ? 4'd3 : 4'd4;
               default:        alu_cmd = op_q;
            endcase
            alu_a   = a_q;
            alu_b   = (op_q == OP_SUB) ? ~b_q : b_q;
            alu_ci  = carry_q;
            wr_en   = 1'b1;
            wr_addr = d_base_q + {6'd0, i_q};
            wr_data = alu_rslt;
            carry_d = chain ? alu_co : 1'b0;
            if (last) begin
               cf_d    = chain ? alu_co : 1'b0;
               state_d = S_DONE;
            end else begin
               i_d     = desc ? (i_q - 2'd1) : (i_q + 2'd1);
               state_d = S_RDA;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            err     = err_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= 4'd0;
         len_q    <= 2'd0;
         i_q      <= 2'd0;
         a_base_q <= 8'h00;
         b_base_q <= 8'h00;
         d_base_q <= 8'h00;
         a_q      <= 8'h00;
         b_q      <= 8'h00;
         carry_q  <= 1'b0;
         cf_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         len_q    <= len_d;
         i_q      <= i_d;
         a_base_q <= a_base_d;
         b_base_q <= b_base_d;
         d_base_q <= d_base_d;
         a_q      <= a_d;
         b_q      <= b_d;
         carry_q  <= carry_d;
         cf_q     <= cf_d;
         err_q    <= err_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign cf        = cf_q;
   assign dbg_state = state_q;

`ifdef ALU_SEQ_PARITY_EN
   logic pf_q, pf_d;

   // Illegal ops never clear or touch the accumulator.
   always_comb begin
      pf_d = pf_q;
      if ((state_q == S_IDLE) && start && !op[3]) pf_d = 1'b0;
      else if (state_q == S_WR)                  pf_d = pf_q ^ (^alu_rslt);
   end

   always_ff @(posedge clk) begin
      if (reset) pf_q <= 1'b0;
      else       pf_q <= pf_d;
   end

   assign pf = pf_q;
`else
   assign pf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: memory and ALU models, vector table, write scoreboard and
// hand-written sequences for illegal ops, start-while-busy and mid-op reset.
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       reset, start, cin_use;
  logic [3:0] op;
  logic [1:0] len_m1;
  logic [7:0] a_base, b_base, d_base;
  logic [7:0] rd_addr, rd_data, wr_addr, wr_data, alu_a, alu_b, alu_rslt;
  logic       wr_en, alu_ci, alu_co, busy, done, err, cf, pf;
  logic [3:0] alu_cmd;
  logic [2:0] dbg_state;

  logic [7:0]  mem [256];
  logic [15:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  len_m1;
    logic        cin_use;
    logic [7:0]  a_base, b_base, d_base;
    logic [31:0] a_val, b_val, exp_d;
    logic        exp_cf;
  } vec_t;

  vec_t vt[16];

  alu_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .len_m1(len_m1), .cin_use(cin_use),
    .a_base(a_base), .b_base(b_base), .d_base(d_base), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alu_cmd(alu_cmd), .alu_a(alu_a),
    .alu_b(alu_b), .alu_ci(alu_ci), .alu_rslt(alu_rslt), .alu_co(alu_co), .busy(busy),
    .done(done), .err(err), .cf(cf), .pf(pf), .dbg_state(dbg_state)
  );

  // clock / memory / ALU models
  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  always_comb begin
    alu_rslt = 8'h00;
    alu_co   = 1'b0;
    case (alu_cmd)
      4'd0: {alu_co, alu_rslt} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_ci};
      4'd2: begin alu_rslt = {alu_a[6:0], alu_ci}; alu_co = alu_a[7]; end
      4'd3: begin alu_rslt = {alu_a[7], alu_a[7:1]}; alu_co = alu_a[0]; end
      4'd4: begin alu_rslt = {alu_ci, alu_a[7:1]}; alu_co = alu_a[0]; end
      4'd5: alu_rslt = ~alu_a;
      4'd6: alu_rslt = alu_a & alu_b;
      4'd7: alu_rslt = alu_a ^ alu_b;
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic sb_check();
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wr_extra: got write %h=%h, expected no write", wr_addr, wr_data);
    end else begin
      e = exp_q.pop_front();
      chk("wr_addr_data", {16'h0, wr_addr, wr_data}, {16'h0, e});
    end
  endtask

  task automatic load(input logic [7:0] base, input logic [31:0] val);
    for (int j = 0; j < 4; j++) mem[base + 8'(j)] = val[8*j +: 8];
  endtask

  task automatic drive(input logic [3:0] o, input logic [1:0] l, input logic c,
                       input logic [7:0] ab, input logic [7:0] bb, input logic [7:0] db);
    @(negedge clk);
    op = o; len_m1 = l; cin_use = c; a_base = ab; b_base = bb; d_base = db;
    start = 1'b1;
  endtask

  // driver + scoreboard push for one command, then latency/flag checks
  task automatic run(input vec_t v);
    int         k;
    int         idx;
    logic       desc;
    logic       exp_pf;
    logic [7:0] eb;
    load(v.a_base, v.a_val);
    load(v.b_base, v.b_val);
    desc   = (v.op == 4'd3) || (v.op == 4'd4);
    exp_pf = 1'b0;
    for (int j = 0; j <= int'(v.len_m1); j++) begin
      idx = desc ? int'(v.len_m1) - j : j;
      eb  = v.exp_d[8*idx +: 8];
      exp_q.push_back({v.d_base + 8'(idx), eb});
      exp_pf ^= ^eb;
    end
`ifndef ALU_SEQ_PARITY_EN
    exp_pf = 1'b0;
`endif
    drive(v.op, v.len_m1, v.cin_use, v.a_base, v.b_base, v.d_base);
    @(posedge clk);
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
      end
      if (wr_en) sb_check();
      if (done) break;
      @(posedge clk);
      k++;
    end
    chk("done_latency", k, 4 * (int'(v.len_m1) + 1));
    chk("err", {31'd0, err}, 32'd0);
    chk("cf", {31'd0, cf}, {31'd0, v.exp_cf});
    chk("pf", {31'd0, pf}, {31'd0, exp_pf});
    chk("sb_empty", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int       wcnt, dcnt;
    logic     cf0, pf0;
    logic [7:0] dmask, emask;
    logic [32:0] sum;
    vec_t     rv;

    vt[0]  = '{4'd0, 2'd1, 1'b0, 8'h10, 8'h20, 8'h30, 32'h0000_12FF, 32'h0000_0001, 32'h0000_1300, 1'b0};
    vt[1]  = '{4'd1, 2'd1, 1'b0, 8'h10, 8'h20, 8'h30, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b1};
    vt[2]  = '{4'd1, 2'd1, 1'b0, 8'h10, 8'h20, 8'h30, 32'h0000_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0};
    vt[3]  = '{4'd2, 2'd2, 1'b0, 8'h10, 8'h20, 8'h30, 32'h0080_0001, 32'h0000_0000, 32'h0000_0002, 1'b1};
    vt[4]  = '{4'd3, 2'd1, 1'b0, 8'h10, 8'h20, 8'h30, 32'h0000_8002, 32'h0000_0000, 32'h0000_C001, 1'b0};
    vt[5]  = '{4'd0, 2'd0, 1'b0, 8'h10, 8'h20, 8'h30, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vt[6]  = '{4'd0, 2'd0, 1'b1, 8'h10, 8'h20, 8'h30, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vt[7]  = '{4'd6, 2'd3, 1'b0, 8'h10, 8'h20, 8'h30, 32'hF0F0_F0F0, 32'hFF00_FF0F, 32'hF000_F000, 1'b0};
    vt[8]  = '{4'd7, 2'd3, 1'b0, 8'h10, 8'h20, 8'h30, 32'h1234_5678, 32'hFFFF_FFFF, 32'hEDCB_A987, 1'b0};
    vt[9]  = '{4'd5, 2'd1, 1'b0, 8'h10, 8'h20, 8'h30, 32'h0000_00FF, 32'h1111_1111, 32'h0000_FF00, 1'b0};
    vt[10] = '{4'd4, 2'd3, 1'b0, 8'h10, 8'h20, 8'h30, 32'h8000_0001, 32'h0000_0000, 32'h4000_0000, 1'b1};
    vt[11] = '{4'd4, 2'd0, 1'b1, 8'h10, 8'h20, 8'h30, 32'h0000_0002, 32'h0000_0000, 32'h0000_0081, 1'b0};
    vt[12] = '{4'd1, 2'd0, 1'b1, 8'h10, 8'h20, 8'h30, 32'h0000_0005, 32'h0000_0002, 32'h0000_0002, 1'b1};
    vt[13] = '{4'd3, 2'd3, 1'b0, 8'h10, 8'h20, 8'h30, 32'h7FFF_FFFE, 32'h0000_0000, 32'h3FFF_FFFF, 1'b0};
    vt[14] = '{4'd0, 2'd1, 1'b0, 8'hFF, 8'h40, 8'hFE, 32'h0000_3456, 32'h0000_0101, 32'h0000_3557, 1'b0};
    vt[15] = '{4'd0, 2'd3, 1'b0, 8'h10, 8'h20, 8'h30, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};

    for (int j = 0; j < 256; j++) mem[j] = 8'h00;
    reset = 1'b1; start = 1'b0; op = 4'd0; len_m1 = 2'd0; cin_use = 1'b0;
    a_base = 8'h00; b_base = 8'h00; d_base = 8'h00;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {26'd0, busy, done, err, wr_en, cf, pf}, 32'd0);
    chk("reset_addr", {8'd0, rd_addr, wr_addr, wr_data}, 32'd0);
    chk("reset_alu", {11'd0, alu_cmd, alu_a, alu_b, alu_ci}, 32'd0);
    chk("reset_state", {29'd0, dbg_state}, 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 16; v++) run(vt[v]);

    // illegal op: immediate done+err, no writes, flags untouched
    cf0 = cf; pf0 = pf; wcnt = 0;
    drive(4'd9, 2'd3, 1'b0, 8'h10, 8'h20, 8'h30);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("illegal_done", {30'd0, done, err}, 32'd3);
    for (int k = 0; k < 6; k++) begin
      if (wr_en) wcnt++;
      @(negedge clk);
    end
    chk("illegal_writes", wcnt, 0);
    chk("illegal_cf", {31'd0, cf}, {31'd0, cf0});
    chk("illegal_pf", {31'd0, pf}, {31'd0, pf0});

    // start held high with an illegal op: ignored in DONE, re-accepted in IDLE
    drive(4'd12, 2'd0, 1'b0, 8'h10, 8'h20, 8'h30);
    @(posedge clk);
    dmask = 8'h00; emask = 8'h00;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 7) start = 1'b0;
      dmask[k] = done;
      emask[k] = err;
      if (k < 7) @(posedge clk);
    end
    chk("held_start_done", {24'd0, dmask}, 32'h55);
    chk("held_start_err", {24'd0, emask}, 32'h55);
    repeat (3) @(negedge clk);

    // random multi-byte ADD/XOR against integer arithmetic
    for (int r = 0; r < 6; r++) begin
      rv = '{4'd0, 2'd3, 1'b0, 8'h80, 8'h90, 8'hA0, 32'h0, 32'h0, 32'h0, 1'b0};
      rv.a_val = $urandom;
      rv.b_val = $urandom_range(32'hFFFF_FFFF, 0);
      if (r[0]) begin
        rv.op    = 4'd7;
        rv.exp_d = rv.a_val ^ rv.b_val;
      end else begin
        sum       = {1'b0, rv.a_val} + {1'b0, rv.b_val};
        rv.exp_d  = sum[31:0];
        rv.exp_cf = sum[32];
      end
      run(rv);
    end

    // start pulses while busy and during DONE are ignored
    load(8'h10, 32'h0000_0010);
    load(8'h20, 32'h0000_0022);
    exp_q.push_back({8'h30, 8'h32});
    drive(4'd0, 2'd0, 1'b0, 8'h10, 8'h20, 8'h30);
    @(posedge clk);
    dcnt = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 1) op = 4'd9;
      if (k == 5) start = 1'b0;
      if (wr_en) sb_check();
      if (done) dcnt++;
      @(posedge clk);
    end
    @(negedge clk);
    chk("busy_start_dones", dcnt, 1);
    chk("busy_start_sb", exp_q.size(), 0);
    chk("busy_start_idle", {31'd0, busy}, 32'd0);
    exp_q.delete();

    // reset during RDB of byte 1 of a 4-byte ADD
    run(vt[5]);
    load(8'h50, 32'h0303_0301);
    load(8'h60, 32'h0000_0000);
    exp_q.push_back({8'h70, 8'h01});
    drive(4'd0, 2'd3, 1'b0, 8'h50, 8'h60, 8'h70);
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (wr_en) sb_check();
      if (k < 5) @(posedge clk);
    end
    chk("rst_mid_state", {29'd0, dbg_state}, 32'd2);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_idle", {29'd0, dbg_state}, 32'd0);
    chk("rst_mid_ctrl", {28'd0, busy, wr_en, cf, pf}, 32'd0);
    chk("rst_mid_sb", exp_q.size(), 0);
    wcnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (wr_en) wcnt++;
    end
    chk("rst_mid_nowrite", wcnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
